// File: rtl/mult8_pkg.sv
// Shared types and constants for the SIMD 8x8-array multiplier.
// Optional signed lane support in mult8_top is enabled by the MULT8_SIGNED_EN macro.
package mult8_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NBYTES  = 4;
  localparam int unsigned LANE8_W  = 8;
  localparam int unsigned LANE16_W = 16;
  localparam int unsigned LANE32_W = 32;

  typedef enum logic [1:0] {
    SEW8     = 2'b00,
    SEW16    = 2'b01,
    SEW32    = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_PART = 2'd2
  } state_e;

endpackage

// File: rtl/mult8_mult8x8.sv
// Combinational unsigned 8x8 -> 16 partial-product multiplier.
module mult8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  assign p = 16'(a) * 16'(b);

endmodule

// File: rtl/mult8_top.sv
// SIMD multiplier: four 8x8, two 16x16 or one 32x32 product from sixteen byte partial products.
// Define MULT8_SIGNED_EN to add the is_signed port for two's-complement lanes.
module mult8_top
  import mult8_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            sew,
  input  logic                  start,
`ifdef MULT8_SIGNED_EN
  input  logic                  is_signed,
`endif
  input  logic [DATA_W-1:0]     data_in_A1,
  input  logic [DATA_W-1:0]     data_in_B1,
  output logic                  count_0,
  output logic [DATA_W-1:0]     product_1,
  output logic [DATA_W-1:0]     product_2,
  output logic [2*DATA_W-1:0]   product
);

  if (DATA_W != 32 || LATENCY != 3) begin : g_bad_cfg
    $error("mult8_top supports only DATA_W=32 and LATENCY=3");
  end

  state_e      state_q, state_d;
  logic        capture;
  logic [31:0] a_q, b_q;
  sew_e        sew_q;
  logic        sgn_q;
  logic [15:0] pp_d [NBYTES][NBYTES];
  logic [15:0] pp_q [NBYTES][NBYTES];
  logic [63:0] res;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        capture = 1'b1;
        state_d = ST_CAPT;
      end
      ST_CAPT: state_d = ST_PART;
      ST_PART: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign count_0 = (state_q == ST_IDLE);

  for (genvar i = 0; i < NBYTES; i++) begin : g_row
    for (genvar j = 0; j < NBYTES; j++) begin : g_col
      mult8x8 u_pp (
        .a (a_q[BYTE_W*i +: BYTE_W]),
        .b (b_q[BYTE_W*j +: BYTE_W]),
        .p (pp_d[i][j])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      sew_q     <= SEW8;
      sgn_q     <= 1'b0;
      pp_q      <= '{default: '0};
      product_1 <= '0;
      product_2 <= '0;
    end else begin
      if (capture) begin
        a_q   <= data_in_A1;
        b_q   <= data_in_B1;
        sew_q <= sew_e'(sew);
`ifdef MULT8_SIGNED_EN
        sgn_q <= is_signed;
`else
        sgn_q <= 1'b0;
`endif
      end
      if (state_q == ST_CAPT) pp_q <= pp_d;
      if (state_q == ST_PART) begin
        product_1 <= res[31:0];
        product_2 <= res[63:32];
      end
    end
  end

  // Shift-and-add: each lane sums only the partial products whose bytes both lie inside it.
  logic [63:0] full;
  logic [31:0] lo16, hi16;
  logic [15:0] l8 [NBYTES];

  always_comb begin
    full = '0;
    lo16 = '0;
    hi16 = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      l8[i] = pp_q[i][i];
      for (int unsigned j = 0; j < NBYTES; j++) begin
        full = full + (64'(pp_q[i][j]) << (BYTE_W * (i + j)));
        if (i < 2 && j < 2)
          lo16 = lo16 + (32'(pp_q[i][j]) << (BYTE_W * (i + j)));
        if (i >= 2 && j >= 2)
          hi16 = hi16 + (32'(pp_q[i][j]) << (BYTE_W * (i + j - 4)));
      end
    end
`ifdef MULT8_SIGNED_EN
    // Two's-complement fix-up: subtract the other operand shifted by lane width per negative operand.
    if (sgn_q) begin
      for (int unsigned k = 0; k < NBYTES; k++) begin
        l8[k] = l8[k]
              - (a_q[BYTE_W*k + 7] ? {b_q[BYTE_W*k +: BYTE_W], 8'h00} : 16'h0000)
              - (b_q[BYTE_W*k + 7] ? {a_q[BYTE_W*k +: BYTE_W], 8'h00} : 16'h0000);
      end
      lo16 = lo16 - (a_q[15] ? {b_q[15:0], 16'h0000} : 32'h0)
                  - (b_q[15] ? {a_q[15:0], 16'h0000} : 32'h0);
      hi16 = hi16 - (a_q[31] ? {b_q[31:16], 16'h0000} : 32'h0)
                  - (b_q[31] ? {a_q[31:16], 16'h0000} : 32'h0);
      full = full - (a_q[31] ? {b_q, 32'h0} : 64'h0)
                  - (b_q[31] ? {a_q, 32'h0} : 64'h0);
    end
`else
    if (sgn_q) full = full;
`endif
    case (sew_q)
      SEW8:    res = {l8[3], l8[2], l8[1], l8[0]};
      SEW16:   res = {hi16, lo16};
      SEW32:   res = full;
      default: res = '0;
    endcase
  end

  assign product = {product_2, product_1};

endmodule

// File: tb/tb_mult8_top.sv
// Directed self-checking bench for mult8_top: lane modes, handshake, busy-start and mid-op reset.
module tb_mult8_top;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sew;
  logic        start;
  logic        is_signed;
  logic [31:0] data_in_A1, data_in_B1;
  logic        count_0;
  logic [31:0] product_1, product_2;
  logic [63:0] product;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] last_prod;

  always #5 clk = ~clk;

  mult8_top #(.DATA_W(32), .LATENCY(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .sew        (sew),
    .start      (start),
`ifdef MULT8_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .data_in_A1 (data_in_A1),
    .data_in_B1 (data_in_B1),
    .count_0    (count_0),
    .product_1  (product_1),
    .product_2  (product_2),
    .product    (product)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single operation with start pulsed for one cycle; operands scrambled after capture.
  task automatic run_op(input string tag, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    sew = s; data_in_A1 = a; data_in_B1 = b; start = 1'b1;
    tick();
    start = 1'b0;
    data_in_A1 = $urandom; data_in_B1 = $urandom; sew = 2'($urandom_range(0, 3));
    check({tag, " busy1"}, {63'b0, count_0}, 64'd0);
    tick();
    check({tag, " hold"}, product, last_prod);
    tick();
    check({tag, " product"}, product, exp);
    check({tag, " p1"}, {32'b0, product_1}, {32'b0, exp[31:0]});
    check({tag, " p2"}, {32'b0, product_2}, {32'b0, exp[63:32]});
    check({tag, " ready"}, {63'b0, count_0}, 64'd1);
    last_prod = exp;
  endtask

  // start stays high; garbage operands during busy cycles must not be accepted.
  task automatic stream_op(input string tag, input logic [1:0] s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    sew = s; data_in_A1 = a; data_in_B1 = b;
    tick();
    data_in_A1 = $urandom; data_in_B1 = $urandom; sew = 2'($urandom_range(0, 2));
    check({tag, " busy1"}, {63'b0, count_0}, 64'd0);
    tick();
    check({tag, " busy2"}, {63'b0, count_0}, 64'd0);
    data_in_A1 = $urandom; data_in_B1 = $urandom;
    tick();
    check({tag, " product"}, product, exp);
    check({tag, " ready"}, {63'b0, count_0}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0; sew = 2'b00; is_signed = 1'b0;
    data_in_A1 = 32'hDEADBEEF; data_in_B1 = 32'hCAFEF00D;
    last_prod = '0;
    tick();
    check("reset ready", {63'b0, count_0}, 64'd1);
    check("reset product", product, 64'd0);
    reset = 1'b1;
    tick();
    check("idle product", product, 64'd0);

    run_op("sew16 vec",   2'b01, 32'h01234567, 32'h89ABCDEF, 64'h009C7D61_37D44629);
    run_op("sew8 vec",    2'b00, 32'h0000FF02, 32'h0000FF03, 64'h00000000_FE010006);
    run_op("sew32 max",   2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    run_op("sew32 small", 2'b10, 32'h00000002, 32'h00000003, 64'h00000000_00000006);
    run_op("sew8 lanes",  2'b00, 32'h04030201, 32'h08070605, 64'h00200015_000C0005);
    run_op("sew8 max",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFE01FE01_FE01FE01);
    run_op("sew16 max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFE0001_FFFE0001);
    run_op("sew rsvd",    2'b11, 32'h12345678, 32'h9ABCDEF0, 64'h0);

    start = 1'b1;
    stream_op("stream0", 2'b10, 32'h00010000, 32'h00010000, 64'h00000001_00000000);
    stream_op("stream1", 2'b00, 32'h10203040, 32'h02020202, 64'h00200040_00600080);
    stream_op("stream2", 2'b01, 32'h00030005, 32'h00070009, 64'h00000015_0000002D);
    start = 1'b0;

    sew = 2'b10; data_in_A1 = 32'hFFFFFFFF; data_in_B1 = 32'hFFFFFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("midrst busy", {63'b0, count_0}, 64'd0);
    reset = 1'b0;
    tick();
    check("midrst ready", {63'b0, count_0}, 64'd1);
    check("midrst product", product, 64'd0);
    reset = 1'b1;
    tick(); tick(); tick();
    check("midrst no stale", product, 64'd0);
    check("midrst idle", {63'b0, count_0}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
